// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned DefMaxLen = 8;
  localparam int unsigned DefCntW   = 8;

  // Width needed to hold a length value in 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// Shift/compare core: history shift register, saturating seen counter and
// length-masked pattern compare. match is combinational for the current edge.
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DefMaxLen,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               bit_in,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               match
);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   seen;
  logic [LEN_W:0]     seen_inc;

  // Next history, compare mask and match decision for the accepting edge.
  always_comb begin
    hist_next = {history[MAX_LEN-2:0], bit_in};
    mask      = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (i < int'(len));
    end
    seen_inc = (LEN_W+1)'(seen) + (LEN_W+1)'(1);
    match    = shift_en && (len != '0) && (seen_inc >= (LEN_W+1)'(len)) &&
               (((hist_next ^ pattern) & mask) == '0);
  end

  // History and seen counter; non-overlap restarts counting after a hit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      history <= '0;
      seen    <= '0;
    end else if (shift_en) begin
      history <= hist_next;
      if (match && !overlap) begin
        seen <= '0;
      end else if (seen < len) begin
        seen <= seen_inc[LEN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detector controller: config registers, FSM,
// valid/ready handshake and match counting around seq_det_core.
// Optional build macro SEQ_DET_FIRST_POS_EN adds the first_pos output.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DefMaxLen,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               in,
  output logic               in_ready,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
`ifdef SEQ_DET_FIRST_POS_EN
  output logic [15:0]        first_pos,
`endif
  output logic               done
);

  state_e             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q;

  logic               len_legal;
  logic               arm;
  logic               accept;
  logic               core_match;
  logic               hit;
  logic [CNT_W:0]     cnt_inc;

  // Handshake, arming and hit decode from the current state.
  always_comb begin
    in_ready  = (state == StArmed);
    busy      = (state == StArmed);
    done      = (state == StDone);
    len_legal = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
    // Rearming from DONE also requires a legal length so the core never runs unmasked.
    arm       = ((state == StIdle) || (state == StDone)) && start && !abort && len_legal;
    accept    = in_valid && in_ready;
    hit       = accept && core_match && !abort;
    cnt_inc   = (CNT_W+1)'(match_cnt) + (CNT_W+1)'(1);
  end

  seq_det_core #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .shift_en(accept),
    .clear   (arm),
    .bit_in  (in),
    .len     (len_q),
    .pattern (pat_q),
    .overlap (ovl_q),
    .match   (core_match)
  );

  // Control FSM with config capture, registered match pulse and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      z         <= 1'b0;
      match_cnt <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      tgt_q     <= '0;
    end else begin
      z <= 1'b0;
      if (cfg_we && (state != StArmed)) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        tgt_q <= cfg_target;
      end
      unique case (state)
        StIdle: begin
          if (arm) begin
            state     <= StArmed;
            match_cnt <= '0;
          end
        end
        StArmed: begin
          if (abort) begin
            state <= StIdle;
          end else if (hit) begin
            z <= 1'b1;
            if (match_cnt != '1) begin
              match_cnt <= cnt_inc[CNT_W-1:0];
            end
            if ((tgt_q != '0) && (cnt_inc == (CNT_W+1)'(tgt_q))) begin
              state <= StDone;
            end
          end
        end
        StDone: begin
          if (abort) begin
            state <= StIdle;
          end else if (arm) begin
            state     <= StArmed;
            match_cnt <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef SEQ_DET_FIRST_POS_EN
  logic [15:0] acc_cnt;
  logic        found;

  // Index of the accepted bit completing the first match since start.
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      acc_cnt   <= '0;
      first_pos <= 16'hFFFF;
      found     <= 1'b0;
    end else if (accept && !abort) begin
      if (hit && !found) begin
        first_pos <= acc_cnt;
        found     <= 1'b1;
      end
      if (acc_cnt != 16'hFFFF) begin
        acc_cnt <= acc_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl; expected z values are queued when a
// bit is driven and compared after the clock edge that consumes it.
module tb_seq_det_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               in_valid;
  logic               in;
  logic               in_ready;
  logic               z;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
`ifdef SEQ_DET_FIRST_POS_EN
  logic [15:0]        first_pos;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_det_ctrl #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_target (cfg_target),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in         (in),
    .in_ready   (in_ready),
    .z          (z),
    .match_cnt  (match_cnt),
    .busy       (busy),
`ifdef SEQ_DET_FIRST_POS_EN
    .first_pos  (first_pos),
`endif
    .done       (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ovl, input logic [CNT_W-1:0] tgt);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_target  = tgt;
    cfg_we      = 1'b1;
    tick();
    cfg_we      = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic drive_bit(input string tag, input logic b, input logic ez);
    in_valid = 1'b1;
    in       = b;
    exp_q.push_back(ez);
    tick();
    in_valid = 1'b0;
    check_eq(tag, 32'(z), 32'(exp_q.pop_front()));
  endtask

  task automatic gap();
    tick();
    check_eq("z_gap", 32'(z), 32'd0);
  endtask

  initial begin
    logic [9:0] s3;
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_z", 32'(z), 32'd0);
    check_eq("rst_cnt", 32'(match_cnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
`ifdef SEQ_DET_FIRST_POS_EN
    check_eq("rst_first_pos", 32'(first_pos), 32'hFFFF);
`endif

    // Pattern 1001, overlapping, unlimited.
    configure(8'b1001, 4'd4, 1'b1, 8'd0);
    do_start();
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_ready", 32'(in_ready), 32'd1);
    drive_bit("t1_z1", 1'b1, 1'b0);
    drive_bit("t1_z2", 1'b0, 1'b0);
    drive_bit("t1_z3", 1'b0, 1'b0);
    drive_bit("t1_z4", 1'b1, 1'b1);
    drive_bit("t1_z5", 1'b0, 1'b0);
    drive_bit("t1_z6", 1'b0, 1'b0);
    drive_bit("t1_z7", 1'b1, 1'b1);
    check_eq("t1_cnt", 32'(match_cnt), 32'd2);
    do_abort();
    check_eq("t1_abort_busy", 32'(busy), 32'd0);
    check_eq("t1_abort_cnt_held", 32'(match_cnt), 32'd2);

    // Same stream, non-overlapping.
    configure(8'b1001, 4'd4, 1'b0, 8'd0);
    do_start();
    check_eq("t2_cnt_clr", 32'(match_cnt), 32'd0);
    drive_bit("t2_z1", 1'b1, 1'b0);
    drive_bit("t2_z2", 1'b0, 1'b0);
    drive_bit("t2_z3", 1'b0, 1'b0);
    drive_bit("t2_z4", 1'b1, 1'b1);
    drive_bit("t2_z5", 1'b0, 1'b0);
    drive_bit("t2_z6", 1'b0, 1'b0);
    drive_bit("t2_z7", 1'b1, 1'b0);
    check_eq("t2_cnt", 32'(match_cnt), 32'd1);
    do_abort();

    // Target 2: DONE after the seventh bit, later bits refused.
    configure(8'b1001, 4'd4, 1'b1, 8'd2);
    do_start();
    s3 = 10'b1001001001;
    for (int i = 9; i >= 0; i--) begin
      drive_bit("t3_z", s3[i], (i == 6) || (i == 3));
      if (i == 3) begin
        check_eq("t3_done", 32'(done), 32'd1);
        check_eq("t3_ready_drop", 32'(in_ready), 32'd0);
      end
    end
    check_eq("t3_cnt", 32'(match_cnt), 32'd2);
    check_eq("t3_busy", 32'(busy), 32'd0);
    check_eq("t3_done_hold", 32'(done), 32'd1);

    // Pattern 101 with gaps and an ignored config write while armed.
    configure(8'b101, 4'd3, 1'b1, 8'd0);
    do_start();
    check_eq("t4_busy", 32'(busy), 32'd1);
    drive_bit("t4_z1", 1'b1, 1'b0);
    gap();
    drive_bit("t4_z2", 1'b0, 1'b0);
    gap();
    gap();
    drive_bit("t4_z3", 1'b1, 1'b1);
    configure(8'b111, 4'd3, 1'b1, 8'd0);
    gap();
    drive_bit("t4_z4", 1'b0, 1'b0);
    drive_bit("t4_z5", 1'b1, 1'b1);
    drive_bit("t4_z6", 1'b1, 1'b0);
    drive_bit("t4_z7", 1'b1, 1'b0);
    check_eq("t4_cnt", 32'(match_cnt), 32'd2);

    // Abort and start together on a completing bit.
    drive_bit("t5_z1", 1'b0, 1'b0);
    abort = 1'b1;
    start = 1'b1;
    drive_bit("t5_z_abort", 1'b1, 1'b0);
    abort = 1'b0;
    start = 1'b0;
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_done", 32'(done), 32'd0);
    check_eq("t5_cnt", 32'(match_cnt), 32'd2);
    tick();
    check_eq("t5_still_idle", 32'(busy), 32'd0);
    configure(8'b101, 4'd0, 1'b1, 8'd0);
    do_start();
    check_eq("t5_len0_busy", 32'(busy), 32'd0);
    check_eq("t5_len0_ready", 32'(in_ready), 32'd0);

    // Reset mid-stream after two matches.
    configure(8'b1001, 4'd4, 1'b1, 8'd0);
    do_start();
    s3 = 10'b1001001100;
    for (int i = 9; i >= 0; i--) begin
      drive_bit("t6_z", s3[i], (i == 6) || (i == 3));
    end
    check_eq("t6_cnt_pre", 32'(match_cnt), 32'd2);
    rst      = 1'b1;
    in_valid = 1'b1;
    in       = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_eq("t6_z", 32'(z), 32'd0);
    check_eq("t6_cnt", 32'(match_cnt), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_done", 32'(done), 32'd0);
    check_eq("t6_ready", 32'(in_ready), 32'd0);
    do_start();
    check_eq("t6_cfg_cleared", 32'(busy), 32'd0);

`ifdef SEQ_DET_FIRST_POS_EN
    configure(8'b11, 4'd2, 1'b1, 8'd0);
    do_start();
    check_eq("fp_init", 32'(first_pos), 32'hFFFF);
    drive_bit("fp_z1", 1'b0, 1'b0);
    drive_bit("fp_z2", 1'b1, 1'b0);
    drive_bit("fp_z3", 1'b1, 1'b1);
    check_eq("fp_pos", 32'(first_pos), 32'd2);
    drive_bit("fp_z4", 1'b1, 1'b1);
    check_eq("fp_pos_held", 32'(first_pos), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial pattern-detector controller. It configures and sequences a shift/compare core that looks for a pattern of up to MAX_LEN bits in a 1-bit input stream. The stream is handshaked with valid/ready. Supports overlapping and non-overlapping match modes, counts matches, and stops after a programmable target count. It replaces fixed-pattern detectors (e.g. hard-wired 1001) wherever the pattern, mode or run length must be set at run time.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and target
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; not to be overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
cfg_we  input  1  configuration write strobe
cfg_pattern  input  MAX_LEN  pattern; bit 0 is the most recently received bit
cfg_len  input  LEN_W  pattern length, legal range 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  input  CNT_W  number of matches before DONE; 0 = unlimited
start  input  1  arm detector
abort  input  1  return to IDLE
in_valid  input  1  input bit valid
in  input  1  serial data bit
in_ready  output  1  controller accepts a bit this cycle
z  output  1  one-cycle match pulse
match_cnt  output  CNT_W  matches since last start
busy  output  1  state is ARMED
done  output  1  state is DONE

Behaviour:
- Reset: state IDLE; z=0, match_cnt=0, busy=0, done=0, in_ready=0. History, seen count and config registers are cleared. A reset asserted mid-operation aborts immediately with no output pulse.
- Config: cfg_we is sampled in IDLE and DONE only; it is ignored in ARMED.
- States:
  - IDLE --start & legal len--> ARMED. If the stored len is 0 or greater than MAX_LEN, start is ignored.
  - ARMED --final match--> DONE.
  - ARMED --abort--> IDLE.
  - DONE --start--> ARMED.
  - DONE --abort--> IDLE.
- Priority: abort beats start. Abort also beats a match on the same edge: the state goes to IDLE and no z pulse is produced.
- Start clears history, the seen counter, match_cnt and z.
- in_ready = (state==ARMED), decoded combinationally from state.
- An accepted bit (in_valid & in_ready) shifts into history: history <= {history[MAX_LEN-2:0], in}. The seen counter increments and saturates at len.
- Match condition: seen+1 >= len and the next history[len-1:0] == pattern[len-1:0]. This is evaluated on the accepting edge.
- Registered result: z=1 for exactly the cycle after the completing accepted bit; match_cnt increments on the same edge and saturates at all-ones.
- Overlap off: on a match, seen resets to 0, so the next match needs len fresh bits.
- Overlap on: history and seen are retained.
- Completion: if target != 0 and match_cnt+1 == target, the state goes to DONE on the same edge as the z pulse. in_ready drops in that cycle, so no further bits are accepted.
- DONE: done=1, busy=0, match_cnt is held.
- IDLE after abort: match_cnt is held until the next start or reset.
- in_valid=0 cycles have no effect (gaps are transparent).

Optional Feature:
SEQ_DET_FIRST_POS_EN
- When defined: adds output first_pos[15:0], the 0-based index of the accepted bit that completed the first match since start. A 16-bit accepted-bit counter saturates at 0xFFFF. first_pos reads 0xFFFF until the first match and is cleared to 0xFFFF on start and on reset.
- When undefined: the port and counter are absent and the block is otherwise identical.

Decomposition:
- Package seq_det_pkg:
  - state enum {IDLE, ARMED, DONE}
  - default MAX_LEN and CNT_W constants
  - LEN_W function
- Sub-module seq_det_core (the natural split):
  - holds the history shift register, seen counter and masked compare
  - inputs: shift enable, clear, len, pattern, overlap
  - outputs: match (combinational, for the current edge)
- seq_det_ctrl owns the FSM, handshake, counters and config registers.

Test Plan:
- Pattern 1001, len 4, overlap=1, target 0; stream 1,0,0,1,0,0,1 → z pulses after bit 4 and bit 7; match_cnt=2.
- Same pattern and stream with overlap=0 → single z after bit 4; match_cnt=1.
- Target 2, overlap=1, pattern 1001; stream 1,0,0,1,0,0,1,0,0,1 → DONE after bit 7; in_ready=0 afterward; match_cnt stays 2; done=1.
- Pattern 101, len 3; in_valid toggled with idle gaps and with cfg_we pulsed in ARMED → detection unaffected; config unchanged.
- Abort and start asserted together in ARMED on a completing bit → IDLE, no z, match_cnt unchanged; start with len=0 → remains IDLE.
- rst pulsed mid-stream after 2 matches → all outputs 0 next cycle. With SEQ_DET_FIRST_POS_EN defined, pattern 11 on stream 0,1,1 → first_pos=2.
